// File: rtl/frame_config_loader.sv
// frame_config_loader: turns a 32-bit config word stream into FrameRegister data and one-hot FrameSelect strobes.
// Latency: the strobe rises the cycle after the last data word (the checksum word when CONFIG_CHECKSUM_EN) and lasts STROBE_CYCLES.
// Backpressure: cfg_ready is registered and is low only during the strobe window. Optional feature macro: CONFIG_CHECKSUM_EN.
module frame_config_loader #(
    parameter int          NUM_ROWS       = 6,
    parameter int          NUM_COLS       = 8,
    parameter int          FRAMES_PER_COL = 36,
    parameter int          STROBE_CYCLES  = 2,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0FAB1
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [31:0]                        cfg_data,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    output logic [32*NUM_ROWS-1:0]             FrameRegister,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0] FrameSelect,
    output logic                               busy,
    output logic                               cfg_error,
    output logic [15:0]                        frames_written
);

    localparam int FR_W  = 32 * NUM_ROWS;
    localparam int FS_W  = NUM_COLS * FRAMES_PER_COL;
    localparam int SEL_W = (FS_W > 1) ? $clog2(FS_W) : 1;
    localparam int CNT_W = $clog2(NUM_ROWS + 1);
    localparam int STB_W = $clog2(STROBE_CYCLES + 1);

    // Header layout: opcode in [31:28], column in [12:8], frame in [5:0]
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_DESYNC = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_STROBE
    } state_t;

    state_t                 state;
    logic [4:0]             col;
    logic [5:0]             frame;
    logic [CNT_W-1:0]       word_cnt;
    logic [STB_W-1:0]       strobe_cnt;

    logic                   xfer;
    logic                   last_word;
    logic                   sum_ok;
    logic                   addr_ok;
    logic [SEL_W-1:0]       sel_idx;
    logic [FS_W-1:0]        sel_onehot;

    assign xfer = cfg_valid & cfg_ready;

    // Latched column/frame must address a real frame; otherwise the frame is dropped with an error
    assign addr_ok    = (int'(col) < NUM_COLS) && (int'(frame) < FRAMES_PER_COL);
    assign sel_idx    = SEL_W'(col) * SEL_W'(FRAMES_PER_COL) + SEL_W'(frame);
    assign sel_onehot = FS_W'(1) << sel_idx;

`ifdef CONFIG_CHECKSUM_EN
    logic [31:0] sum;

    // The word after the last row is the checksum, compared against the running sum
    assign last_word = (word_cnt == CNT_W'(NUM_ROWS));
    assign sum_ok    = (cfg_data == sum);

    // Running modulo-2^32 sum of the data words of the current frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            sum <= '0;
        end else if (state == ST_HDR) begin
            sum <= '0;
        end else if (state == ST_DATA && xfer && !last_word) begin
            sum <= sum + cfg_data;
        end
    end
`else
    assign last_word = (word_cnt == CNT_W'(NUM_ROWS - 1));
    assign sum_ok    = 1'b1;
`endif

    // Session/frame FSM with all outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            col            <= '0;
            frame          <= '0;
            word_cnt       <= '0;
            strobe_cnt     <= '0;
            cfg_ready      <= 1'b1;
            FrameRegister  <= '0;
            FrameSelect    <= '0;
            busy           <= 1'b0;
            cfg_error      <= 1'b0;
            frames_written <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Anything other than the sync word is swallowed
                    if (xfer && cfg_data == SYNC_WORD) begin
                        state <= ST_HDR;
                        busy  <= 1'b1;
                    end
                end

                ST_HDR: begin
                    if (xfer) begin
                        if (cfg_data[31:28] == OP_WRITE) begin
                            col      <= cfg_data[12:8];
                            frame    <= cfg_data[5:0];
                            word_cnt <= '0;
                            state    <= ST_DATA;
                        end else if (cfg_data[31:28] == OP_DESYNC) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        // Word i lands in row slice i, row 1 at the top of the bus
                        for (int r = 0; r < NUM_ROWS; r++) begin
                            if (word_cnt == CNT_W'(r)) begin
                                FrameRegister[FR_W-1-32*r -: 32] <= cfg_data;
                            end
                        end
                        if (last_word) begin
                            if (!sum_ok || !addr_ok) begin
                                cfg_error <= 1'b1;
                                state     <= ST_HDR;
                            end else begin
                                FrameSelect <= sel_onehot;
                                strobe_cnt  <= '0;
                                cfg_ready   <= 1'b0;
                                state       <= ST_STROBE;
                            end
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_STROBE: begin
                    // FrameRegister is frozen here, so the fabric sees stable data while the strobe is high
                    if (strobe_cnt == STB_W'(STROBE_CYCLES - 1)) begin
                        FrameSelect <= '0;
                        cfg_ready   <= 1'b1;
                        state       <= ST_HDR;
                        if (frames_written != 16'hFFFF) begin
                            frames_written <= frames_written + 16'd1;
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt + STB_W'(1);
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    cfg_ready   <= 1'b1;
                    FrameSelect <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader: directed stimulus with a strobe scoreboard for frame_config_loader.
// Expected frames are queued when their words are driven and popped when FrameSelect rises.
// All sampling happens on the falling clock edge; inputs change there too.
module tb_frame_config_loader;

    localparam int          NUM_ROWS      = 6;
    localparam int          NUM_COLS      = 8;
    localparam int          FPC           = 36;
    localparam int          STROBE_CYCLES = 2;
    localparam logic [31:0] SYNC          = 32'hFAB0FAB1;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [191:0] FrameRegister;
    logic [287:0] FrameSelect;
    logic         busy;
    logic         cfg_error;
    logic [15:0]  frames_written;

    typedef struct {
        int           idx;
        logic [191:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           run_len  = 0;
    bit           hold_ok  = 0;
    logic [287:0] hold_sel;
    logic [191:0] hold_data;
    logic [191:0] d;

    always #5 CLK = ~CLK;

    frame_config_loader #(
        .NUM_ROWS       (NUM_ROWS),
        .NUM_COLS       (NUM_COLS),
        .FRAMES_PER_COL (FPC),
        .STROBE_CYCLES  (STROBE_CYCLES),
        .SYNC_WORD      (SYNC)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .FrameRegister  (FrameRegister),
        .FrameSelect    (FrameSelect),
        .busy           (busy),
        .cfg_error      (cfg_error),
        .frames_written (frames_written)
    );

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; then the strobe monitor/scoreboard runs on the falling edge
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        @(negedge CLK);
        check("ready_vs_strobe", 288'(cfg_ready), 288'(FrameSelect == '0));
        if (FrameSelect != '0) begin
            if (run_len == 0) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_strobe observed=%0h expected=none", FrameSelect);
                end
                hold_ok = 0;
                if (exp_q.size() > 0) begin
                    e         = exp_q.pop_front();
                    hold_sel  = 288'd1 << e.idx;
                    hold_data = e.data;
                    hold_ok   = 1;
                    check("strobe_sel", FrameSelect, hold_sel);
                    check("strobe_data", 288'(FrameRegister), 288'(hold_data));
                end
            end else if (hold_ok) begin
                check("strobe_sel_hold", FrameSelect, hold_sel);
                check("strobe_data_hold", 288'(FrameRegister), 288'(hold_data));
            end
            run_len++;
        end else if (run_len != 0) begin
            check("strobe_len", 288'(run_len), 288'(STROBE_CYCLES));
            run_len = 0;
        end
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Holds cfg_valid high until the word is taken; returns on the falling edge after the transfer
    task automatic send_word(input logic [31:0] w);
        bit acc = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = cfg_ready;
            tick();
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted word=%0h", w);
        end
    endtask

    // Header plus NUM_ROWS words (plus checksum when enabled); queues the expected strobe first
    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] seed, input bit expect_strobe,
                              input logic [31:0] sum_adj, output logic [191:0] data);
        logic [31:0] w[NUM_ROWS];
        logic [31:0] sum;
        exp_t        e;
        sum  = '0;
        data = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            w[i] = seed ^ (32'(i + 1) * 32'h9E3779B9);
            sum  = sum + w[i];
            data = {data[159:0], w[i]};
        end
        if (expect_strobe) begin
            e.idx  = int'(hdr[12:8]) * FPC + int'(hdr[5:0]);
            e.data = data;
            exp_q.push_back(e);
        end
        send_word(hdr);
        for (int i = 0; i < NUM_ROWS; i++) send_word(w[i]);
`ifdef CONFIG_CHECKSUM_EN
        send_word(sum + sum_adj);
`else
        if (sum_adj != 0) sum = sum + sum_adj;
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_cfg_ready", 288'(cfg_ready), 288'(1'b1));
        check("rst_frame_register", 288'(FrameRegister), 288'd0);
        check("rst_frame_select", FrameSelect, 288'd0);
        check("rst_busy", 288'(busy), 288'd0);
        check("rst_cfg_error", 288'(cfg_error), 288'd0);
        check("rst_frames_written", 288'(frames_written), 288'd0);
    endtask

    initial begin
        RST       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        tick();
        tick();
        check_reset_outputs();
        RST = 1'b0;

        // Garbage before sync is dropped
        send_word(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        idle(3);
        check("junk_busy", 288'(busy), 288'd0);
        check("junk_frame_register", 288'(FrameRegister), 288'd0);
        check("junk_frames_written", 288'(frames_written), 288'd0);

        // Sync, then a frame to col 3 / frame 5
        send_word(SYNC);
        check("sync_busy", 288'(busy), 288'd1);
        send_frame(32'h1000_0305, 32'hA5A5_0000, 1, 32'd0, d);
        idle(4);
        check("f1_frames_written", 288'(frames_written), 288'd1);
        check("f1_register_holds", 288'(FrameRegister), 288'(d));
        check("f1_cfg_error", 288'(cfg_error), 288'd0);
        check("f1_busy", 288'(busy), 288'd1);

        // Column out of range: data still lands, no strobe, sticky error
        send_frame(32'h1000_0800, 32'h1234_5678, 0, 32'd0, d);
        idle(4);
        check("badcol_cfg_error", 288'(cfg_error), 288'd1);
        check("badcol_frames_written", 288'(frames_written), 288'd1);
        check("badcol_register", 288'(FrameRegister), 288'(d));

        // Frame index one past the last legal frame
        send_frame(32'h1000_0024, 32'h0F0F_0F0F, 0, 32'd0, d);
        idle(4);
        check("badframe_frames_written", 288'(frames_written), 288'd1);

        // Highest legal strobe bit (col 7, frame 35)
        send_frame(32'h1000_0723, 32'hCAFE_0000, 1, 32'd0, d);
        idle(4);
        check("top_frames_written", 288'(frames_written), 288'd2);
        check("top_error_sticky", 288'(cfg_error), 288'd1);

        // Unknown opcode keeps the loader in header state
        send_word(32'h2000_0000);
        check("badop_busy", 288'(busy), 288'd1);

        // Two frames back to back with valid held high; the second header has junk in ignored bits
        send_frame(32'h1000_0000, 32'h5555_AAAA, 1, 32'd0, d);
        send_frame(32'h1ABC_E6DF, 32'h0BAD_F00D, 1, 32'd0, d);
        idle(4);
        check("b2b_frames_written", 288'(frames_written), 288'd4);
        check("b2b_register", 288'(FrameRegister), 288'(d));

        // Desync returns to idle
        send_word(32'hD000_0000);
        check("desync_busy", 288'(busy), 288'd0);

        // Reset lands while the third data word is being transferred
        send_word(SYNC);
        send_word(32'h1000_0102);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        RST       = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 32'h3333_3333;
        tick();
        check_reset_outputs();
        RST = 1'b0;

        // Back in idle: a write header without sync must not start a frame
        send_word(32'h1000_0000);
        for (int i = 0; i < NUM_ROWS; i++) send_word(32'h7000_0000 + 32'(i));
        idle(4);
        check("postrst_busy", 288'(busy), 288'd0);
        check("postrst_frame_register", 288'(FrameRegister), 288'd0);
        check("postrst_frames_written", 288'(frames_written), 288'd0);

`ifdef CONFIG_CHECKSUM_EN
        send_word(SYNC);
        send_frame(32'h1000_0101, 32'h600D_5000, 1, 32'd0, d);
        idle(4);
        check("sum_ok_frames_written", 288'(frames_written), 288'd1);
        check("sum_ok_cfg_error", 288'(cfg_error), 288'd0);
        send_frame(32'h1000_0202, 32'hBAAD_5000, 0, 32'd1, d);
        idle(4);
        check("sum_bad_cfg_error", 288'(cfg_error), 288'd1);
        check("sum_bad_frames_written", 288'(frames_written), 288'd1);
        send_word(32'hD000_0000);
        check("sum_desync_busy", 288'(busy), 288'd0);
`endif

        idle(5);
        check("pending_strobes", 288'(exp_q.size()), 288'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
